// File: rtl/oled_spi_responder.sv
// SSD1306-style SPI display responder: oversamples the OLED bus, assembles bytes,
// tracks display state from command bytes and turns data bytes into frame-buffer writes.
module oled_spi_responder #(
  parameter int SYNC_STAGES = 2,
  parameter int PAGES       = 4,
  parameter int COLUMNS     = 128
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        oled_spi_clk,
  input  logic                                        oled_spi_data,
  input  logic                                        oled_dc_n,
  input  logic                                        oled_reset_n,
  input  logic                                        oled_vdd,
  input  logic                                        oled_vbat,
  output logic                                        fb_we,
  output logic [$clog2(PAGES)+$clog2(COLUMNS)-1:0]    fb_addr,
  output logic [7:0]                                  fb_wdata,
  output logic                                        byte_valid,
  output logic [7:0]                                  byte_data,
  output logic                                        byte_dc,
  output logic                                        display_on,
  output logic [7:0]                                  contrast,
  output logic                                        charge_pump_en,
  output logic                                        seg_remap,
  output logic                                        com_scan_rev,
  output logic                                        powered,
  output logic                                        cmd_error
);

  localparam int PW = $clog2(PAGES);
  localparam int CW = $clog2(COLUMNS);

  typedef enum logic [1:0] {CMD, ARG1, ARG2} state_t;

  typedef struct packed {
    state_t          state;
    logic [7:0]      op;
    logic [PW-1:0]   page;
    logic [PW-1:0]   pageStart;
    logic [PW-1:0]   pageEnd;
    logic [CW-1:0]   col;
    logic [CW-1:0]   colStart;
    logic [CW-1:0]   colEnd;
    logic            horz;
    logic            displayOn;
    logic [7:0]      contrast;
    logic            chargePump;
    logic            segRemap;
    logic            comScanRev;
  } dec_t;

  localparam dec_t DEC_RESET = '{state: CMD, op: 8'h00, page: '0, pageStart: '0,
                                 pageEnd: PW'(PAGES - 1), col: '0, colStart: '0,
                                 colEnd: CW'(COLUMNS - 1), horz: 1'b0, displayOn: 1'b0,
                                 contrast: 8'h7F, chargePump: 1'b0, segRemap: 1'b0,
                                 comScanRev: 1'b0};

  // Synchronizer bit order {vbat, vdd, reset_n, dc, data, sck}; supplies reset to "off"
  // and the display reset to "asserted" so nothing decodes until real inputs arrive.
  localparam logic [5:0] SYNC_RESET = 6'b110000;

  logic [5:0] r_sync [SYNC_STAGES];
  logic       r_sckPrev;
  logic [2:0] r_bitCnt;
  logic [7:0] r_shift;
  dec_t       r_dec;

  logic [5:0] w_syncOut;
  logic       w_sck, w_sda, w_dc, w_rstn, w_vdd, w_vbat, w_sckRise;

  assign w_syncOut = r_sync[SYNC_STAGES-1];
  assign {w_vbat, w_vdd, w_rstn, w_dc, w_sda, w_sck} = w_syncOut;
  assign w_sckRise = w_sck & ~r_sckPrev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= SYNC_RESET;
    end else begin
      r_sync[0] <= {oled_vbat, oled_vdd, oled_reset_n, oled_dc_n, oled_spi_data, oled_spi_clk};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Byte assembly; a display reset discards any partially shifted byte.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sckPrev  <= 1'b0;
      r_bitCnt   <= 3'd0;
      r_shift    <= 8'h00;
      byte_valid <= 1'b0;
      byte_data  <= 8'h00;
      byte_dc    <= 1'b0;
      powered    <= 1'b0;
    end else begin
      r_sckPrev  <= w_sck;
      powered    <= ~w_vdd & ~w_vbat;
      byte_valid <= 1'b0;
      if (!w_rstn) begin
        r_bitCnt  <= 3'd0;
        r_shift   <= 8'h00;
        byte_data <= 8'h00;
        byte_dc   <= 1'b0;
      end else if (w_sckRise) begin
        r_shift  <= {r_shift[6:0], w_sda};
        r_bitCnt <= r_bitCnt + 3'd1;
        if (r_bitCnt == 3'd7 && !w_vdd) begin
          byte_valid <= 1'b1;
          byte_data  <= {r_shift[6:0], w_sda};
          byte_dc    <= w_dc;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dec     <= DEC_RESET;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= 8'h00;
      cmd_error <= 1'b0;
    end else if (!w_rstn) begin
      r_dec     <= DEC_RESET;
      fb_we     <= 1'b0;
      fb_addr   <= '0;
      fb_wdata  <= 8'h00;
      cmd_error <= 1'b0;
    end else begin
      fb_we     <= 1'b0;
      cmd_error <= 1'b0;
      if (byte_valid && byte_dc) begin
        fb_we    <= 1'b1;
        fb_addr  <= {r_dec.page, r_dec.col};
        fb_wdata <= byte_data;
        // Data arriving while an argument is pending aborts the command but is still written.
        if (r_dec.state != CMD) begin
          cmd_error   <= 1'b1;
          r_dec.state <= CMD;
        end
        if (r_dec.col == r_dec.colEnd) begin
          r_dec.col <= r_dec.colStart;
          if (r_dec.horz)
            r_dec.page <= (r_dec.page == r_dec.pageEnd) ? r_dec.pageStart : r_dec.page + 1'b1;
        end else begin
          r_dec.col <= r_dec.col + 1'b1;
        end
      end else if (byte_valid) begin
        case (r_dec.state)
          CMD: begin
            case (byte_data)
              8'hAE, 8'hAF: r_dec.displayOn  <= byte_data[0];
              8'hA0, 8'hA1: r_dec.segRemap   <= byte_data[0];
              8'hC0:        r_dec.comScanRev <= 1'b0;
              8'hC8:        r_dec.comScanRev <= 1'b1;
              8'h81, 8'h8D, 8'hD9, 8'hDA, 8'h20, 8'h21, 8'h22: begin
                r_dec.op    <= byte_data;
                r_dec.state <= ARG1;
              end
              default: begin
                if (byte_data[7:4] == 4'h0)
                  r_dec.col[3:0] <= byte_data[3:0];
                else if (byte_data[7:3] == 5'b00010)
                  r_dec.col[CW-1:4] <= byte_data[CW-5:0];
                else
                  cmd_error <= 1'b1;
              end
            endcase
          end
          ARG1: begin
            case (r_dec.op)
              8'h81: r_dec.contrast   <= byte_data;
              8'h8D: r_dec.chargePump <= byte_data[2];
              8'h20: r_dec.horz       <= (byte_data[1:0] == 2'b00);
              8'h21: begin
                r_dec.colStart <= byte_data[CW-1:0];
                r_dec.col      <= byte_data[CW-1:0];
              end
              8'h22: begin
                r_dec.pageStart <= byte_data[PW-1:0];
                r_dec.page      <= byte_data[PW-1:0];
              end
              default: ;
            endcase
            r_dec.state <= (r_dec.op == 8'h21 || r_dec.op == 8'h22) ? ARG2 : CMD;
          end
          ARG2: begin
            if (r_dec.op == 8'h21) r_dec.colEnd  <= byte_data[CW-1:0];
            else                   r_dec.pageEnd <= byte_data[PW-1:0];
            r_dec.state <= CMD;
          end
          default: r_dec.state <= CMD;
        endcase
      end
    end
  end

  assign display_on     = r_dec.displayOn;
  assign contrast       = r_dec.contrast;
  assign charge_pump_en = r_dec.chargePump;
  assign seg_remap      = r_dec.segRemap;
  assign com_scan_rev   = r_dec.comScanRev;

endmodule

// File: tb/tb_oled_spi_responder.sv
// Bench for oled_spi_responder: drives SPI bytes at clock/4 and compares strobes, timing
// and display state against a byte-level model of the controller's command set.
module tb_oled_spi_responder;

  logic       clock = 1'b0;
  logic       reset;
  logic       oled_spi_clk, oled_spi_data, oled_dc_n, oled_reset_n, oled_vdd, oled_vbat;
  logic       fb_we, byte_valid, byte_dc, display_on, charge_pump_en;
  logic       seg_remap, com_scan_rev, powered, cmd_error;
  logic [8:0] fb_addr;
  logic [7:0] fb_wdata, byte_data, contrast;

  oled_spi_responder #(.SYNC_STAGES(2), .PAGES(4), .COLUMNS(128)) dut (
    .clock(clock), .reset(reset), .oled_spi_clk(oled_spi_clk), .oled_spi_data(oled_spi_data),
    .oled_dc_n(oled_dc_n), .oled_reset_n(oled_reset_n), .oled_vdd(oled_vdd), .oled_vbat(oled_vbat),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_wdata(fb_wdata), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_dc(byte_dc), .display_on(display_on), .contrast(contrast),
    .charge_pump_en(charge_pump_en), .seg_remap(seg_remap), .com_scan_rev(com_scan_rev),
    .powered(powered), .cmd_error(cmd_error));

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0]  addr;
    logic [7:0]  data;
    logic        dc;
    logic [31:0] stamp;
  } ev_t;

  ev_t obsValid[$], expValid[$], obsWrite[$], expWrite[$];
  int  cycleCnt = 0;
  int  obsErr = 0, expErr = 0;
  int  total = 0, bad = 0;
  int  mOn, mContrast, mCp, mSeg, mCom, mPage, mCol, mPs, mPe, mCs, mCe, mHorz, mOp, mArgs, mArgIdx;
  localparam logic [41:0] RESET_OUTS = {1'b0, 9'd0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 8'h7F, 5'b0};

  always @(posedge clock) cycleCnt++;

  always @(negedge clock) begin
    ev_t e;
    if (!reset) begin
      if (byte_valid) begin
        e.addr = 9'd0; e.data = byte_data; e.dc = byte_dc; e.stamp = 32'(cycleCnt);
        obsValid.push_back(e);
      end
      if (fb_we) begin
        e.addr = fb_addr; e.data = fb_wdata; e.dc = 1'b1; e.stamp = 32'(cycleCnt);
        obsWrite.push_back(e);
      end
      if (cmd_error) obsErr++;
    end
  end

  function automatic logic [41:0] allOuts();
    return {fb_we, fb_addr, fb_wdata, byte_valid, byte_data, byte_dc, display_on, contrast,
            charge_pump_en, seg_remap, com_scan_rev, powered, cmd_error};
  endfunction

  function automatic logic [11:0] dutStatus();
    return {display_on, contrast, charge_pump_en, seg_remap, com_scan_rev};
  endfunction

  function automatic logic [11:0] modelStatus();
    return {1'(mOn), 8'(mContrast), 1'(mCp), 1'(mSeg), 1'(mCom)};
  endfunction

  task automatic modelReset();
    mOn = 0; mContrast = 127; mCp = 0; mSeg = 0; mCom = 0; mPage = 0; mCol = 0;
    mPs = 0; mPe = 3; mCs = 0; mCe = 127; mHorz = 0; mOp = 0; mArgs = 0; mArgIdx = 0;
  endtask

  // Reference behaviour per received byte; stamp is the cycle of the byte's 8th SCK rise.
  task automatic modelByte(input int b, input bit dc, input int stamp);
    ev_t e;
    e.addr = 9'd0; e.data = 8'(b); e.dc = dc; e.stamp = 32'(stamp + 3);
    expValid.push_back(e);
    if (dc) begin
      if (mArgs > 0) begin expErr++; mArgs = 0; mArgIdx = 0; end
      e.addr = 9'(mPage * 128 + mCol); e.dc = 1'b1; e.stamp = 32'(stamp + 4);
      expWrite.push_back(e);
      if (mCol == mCe) begin
        mCol = mCs;
        if (mHorz != 0) mPage = (mPage == mPe) ? mPs : (mPage + 1) % 4;
      end else begin
        mCol = (mCol + 1) % 128;
      end
    end else if (mArgs == 0) begin
      mArgIdx = 0;
      if (b == 'hAE) mOn = 0;
      else if (b == 'hAF) mOn = 1;
      else if (b == 'hA0 || b == 'hA1) mSeg = b - 'hA0;
      else if (b == 'hC0) mCom = 0;
      else if (b == 'hC8) mCom = 1;
      else if (b < 16) mCol = (mCol / 16) * 16 + b;
      else if (b < 24) mCol = (b - 16) * 16 + mCol % 16;
      else if (b inside {'h81, 'h8D, 'hD9, 'hDA, 'h20}) begin mOp = b; mArgs = 1; end
      else if (b == 'h21 || b == 'h22) begin mOp = b; mArgs = 2; end
      else expErr++;
    end else begin
      if (mArgIdx == 0) begin
        case (mOp)
          'h81: mContrast = b;
          'h8D: mCp = (b / 4) % 2;
          'h20: mHorz = (b % 4 == 0) ? 1 : 0;
          'h21: begin mCs = b % 128; mCol = mCs; end
          'h22: begin mPs = b % 4; mPage = mPs; end
          default: ;
        endcase
      end else if (mOp == 'h21) mCe = b % 128;
      else mPe = b % 4;
      mArgIdx++;
      mArgs--;
    end
  endtask

  task automatic sendBits(input logic [7:0] b, input logic dc, input int n, output int stamp);
    stamp = 0;
    for (int i = 7; i > 7 - n; i--) begin
      oled_spi_clk = 1'b0; oled_spi_data = b[i]; oled_dc_n = dc;
      repeat (2) @(posedge clock);
      #1 oled_spi_clk = 1'b1;
      stamp = cycleCnt;
      repeat (2) @(posedge clock);
      #1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic dc);
    int stamp;
    sendBits(b, dc, 8, stamp);
    if (oled_vdd == 1'b0) modelByte(int'(b), dc, stamp);
  endtask

  task automatic settle();
    oled_spi_clk = 1'b0;
    repeat (8) @(posedge clock);
    #1;
  endtask

  task automatic clearQueues();
    obsValid.delete(); expValid.delete(); obsWrite.delete(); expWrite.delete();
    obsErr = 0; expErr = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    oled_spi_clk = 0; oled_spi_data = 0; oled_dc_n = 0; oled_reset_n = 1; oled_vdd = 1; oled_vbat = 1;
    modelReset();
    repeat (3) @(negedge clock);
    total++;
    if (allOuts() !== RESET_OUTS) begin
      bad++; $display("[TB] FAIL reset_held: got %h want %h", allOuts(), RESET_OUTS);
    end
    @(posedge clock); #1 reset = 1'b0;
    repeat (6) @(negedge clock);
    total++;
    if (allOuts() !== RESET_OUTS) begin
      bad++; $display("[TB] FAIL reset_released: got %h want %h", allOuts(), RESET_OUTS);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_init_sequence();
    logic [7:0] seq [12] = '{8'hAE, 8'h8D, 8'h14, 8'hD9, 8'hF1, 8'h81, 8'hFF, 8'hA0, 8'hC0, 8'hDA, 8'h00, 8'hAF};
    oled_vdd = 1'b0; oled_vbat = 1'b0;
    repeat (6) @(posedge clock); #1;
    total++;
    if (powered !== 1'b1) begin bad++; $display("[TB] FAIL init_powered: got %b want 1", powered); end
    foreach (seq[i]) sendByte(seq[i], 1'b0);
    settle();
    total++;
    if (obsValid.size() != 12 || expValid.size() != 12) begin
      bad++; $display("[TB] FAIL init_count: got %0d want 12", obsValid.size());
    end
    foreach (expValid[i]) if (i < obsValid.size()) begin
      total++;
      if (obsValid[i] !== expValid[i]) begin
        bad++; $display("[TB] FAIL init_byte%0d: got %h/%b@%0d want %h/%b@%0d", i, obsValid[i].data,
                        obsValid[i].dc, obsValid[i].stamp, expValid[i].data, expValid[i].dc, expValid[i].stamp);
      end
    end
    total++;
    if (obsWrite.size() != 0 || obsErr != 0) begin
      bad++; $display("[TB] FAIL init_quiet: got writes=%0d errs=%0d want 0/0", obsWrite.size(), obsErr);
    end
    total++;
    if (dutStatus() !== {1'b1, 8'hFF, 1'b1, 1'b0, 1'b0}) begin
      bad++; $display("[TB] FAIL init_status: got %h want %h", dutStatus(), {1'b1, 8'hFF, 1'b1, 1'b0, 1'b0});
    end
    clearQueues();
  endtask

  task automatic test_page_write();
    logic [7:0] cmds [9] = '{8'h22, 8'h01, 8'h02, 8'h10, 8'h22, 8'h00, 8'h03, 8'h07, 8'h17};
    for (int i = 0; i < 4; i++) sendByte(cmds[i], 1'b0);
    for (int i = 1; i <= 8; i++) sendByte(8'(i * 'h11), 1'b1);
    for (int i = 4; i < 9; i++) sendByte(cmds[i], 1'b0);
    sendByte(8'hAA, 1'b1);
    sendByte(8'hBB, 1'b1);
    settle();
    total++;
    if (obsWrite.size() != expWrite.size()) begin
      bad++; $display("[TB] FAIL page_count: got %0d want %0d", obsWrite.size(), expWrite.size());
    end
    foreach (expWrite[i]) if (i < obsWrite.size()) begin
      total++;
      if (obsWrite[i] !== expWrite[i]) begin
        bad++; $display("[TB] FAIL page_write%0d: got %h<=%h@%0d want %h<=%h@%0d", i, obsWrite[i].addr,
                        obsWrite[i].data, obsWrite[i].stamp, expWrite[i].addr, expWrite[i].data, expWrite[i].stamp);
      end
    end
    total++;
    if (obsErr !== expErr || obsValid.size() != expValid.size()) begin
      bad++; $display("[TB] FAIL page_misc: got errs=%0d bytes=%0d want %0d/%0d", obsErr, obsValid.size(),
                      expErr, expValid.size());
    end
    clearQueues();
  endtask

  task automatic test_horz_wrap();
    logic [7:0] cmds [8] = '{8'h20, 8'h00, 8'h22, 8'h03, 8'h03, 8'h21, 8'h7F, 8'h7F};
    foreach (cmds[i]) sendByte(cmds[i], 1'b0);
    sendByte(8'h3C, 1'b1);
    sendByte(8'hC3, 1'b1);
    settle();
    total++;
    if (obsWrite.size() != 2) begin
      bad++; $display("[TB] FAIL horz_count: got %0d want 2", obsWrite.size());
    end
    foreach (expWrite[i]) if (i < obsWrite.size()) begin
      total++;
      if (obsWrite[i] !== expWrite[i] || obsWrite[i].addr !== 9'h1FF) begin
        bad++; $display("[TB] FAIL horz_write%0d: got %h<=%h@%0d want 1ff<=%h@%0d", i, obsWrite[i].addr,
                        obsWrite[i].data, obsWrite[i].stamp, expWrite[i].data, expWrite[i].stamp);
      end
    end
    clearQueues();
  endtask

  task automatic test_arg_error();
    sendByte(8'h81, 1'b0);
    sendByte(8'h55, 1'b1);
    settle();
    total++;
    if (obsErr !== 1) begin bad++; $display("[TB] FAIL argerr_pulse: got %0d want 1", obsErr); end
    total++;
    if (obsWrite.size() != 1 || (obsWrite.size() == 1 && obsWrite[0] !== expWrite[0])) begin
      bad++; $display("[TB] FAIL argerr_write: got %0d writes want %h<=55", obsWrite.size(), expWrite[0].addr);
    end
    total++;
    if (dutStatus() !== modelStatus() || contrast !== 8'hFF) begin
      bad++; $display("[TB] FAIL argerr_status: got %h want %h", dutStatus(), modelStatus());
    end
    clearQueues();
  endtask

  task automatic test_drop();
    oled_vdd = 1'b1;
    repeat (6) @(posedge clock); #1;
    total++;
    if (powered !== 1'b0) begin bad++; $display("[TB] FAIL drop_powered: got %b want 0", powered); end
    sendByte(8'hAE, 1'b0);
    settle();
    total++;
    if (obsValid.size() != 0 || display_on !== 1'b1) begin
      bad++; $display("[TB] FAIL drop_byte: got bytes=%0d on=%b want 0/1", obsValid.size(), display_on);
    end
    oled_vdd = 1'b0;
    repeat (6) @(posedge clock); #1;
    clearQueues();
  endtask

  task automatic test_display_reset();
    int stamp;
    sendByte(8'h81, 1'b0);
    sendByte(8'h10, 1'b0);
    sendBits(8'hFF, 1'b0, 5, stamp);
    oled_spi_clk = 1'b0;
    repeat (2) @(posedge clock);
    #1 oled_reset_n = 1'b0;
    repeat (4) @(posedge clock);
    #1 oled_reset_n = 1'b1;
    repeat (4) @(posedge clock);
    #1 modelReset();
    sendByte(8'hAF, 1'b0);
    settle();
    total++;
    if (obsValid.size() != 3) begin
      bad++; $display("[TB] FAIL dreset_count: got %0d want 3", obsValid.size());
    end
    foreach (expValid[i]) if (i < obsValid.size()) begin
      total++;
      if (obsValid[i] !== expValid[i]) begin
        bad++; $display("[TB] FAIL dreset_byte%0d: got %h@%0d want %h@%0d", i, obsValid[i].data,
                        obsValid[i].stamp, expValid[i].data, expValid[i].stamp);
      end
    end
    total++;
    if (dutStatus() !== modelStatus() || display_on !== 1'b1 || contrast !== 8'h7F) begin
      bad++; $display("[TB] FAIL dreset_status: got %h want %h", dutStatus(), modelStatus());
    end
    clearQueues();
  endtask

  task automatic test_async_reset();
    int stamp;
    sendByte(8'hA1, 1'b0);
    sendByte(8'hC8, 1'b0);
    sendBits(8'h00, 1'b0, 3, stamp);
    reset = 1'b1;
    @(negedge clock);
    total++;
    if (allOuts() !== RESET_OUTS) begin
      bad++; $display("[TB] FAIL areset_outs: got %h want %h", allOuts(), RESET_OUTS);
    end
    @(posedge clock); #1;
    oled_spi_clk = 1'b0;
    reset = 1'b0;
    modelReset();
    repeat (6) @(posedge clock); #1;
    sendByte(8'hA1, 1'b0);
    settle();
    total++;
    if (obsValid.size() != 3 || (obsValid.size() == 3 && obsValid[2] !== expValid[2])) begin
      bad++; $display("[TB] FAIL areset_bytes: got %0d bytes want 3 ending %h", obsValid.size(), expValid[2].data);
    end
    total++;
    if (dutStatus() !== modelStatus() || seg_remap !== 1'b1 || com_scan_rev !== 1'b0) begin
      bad++; $display("[TB] FAIL areset_status: got %h want %h", dutStatus(), modelStatus());
    end
    clearQueues();
  endtask

  task automatic test_random();
    logic [7:0] singles [6] = '{8'hAE, 8'hAF, 8'hA0, 8'hA1, 8'hC0, 8'hC8};
    logic [7:0] oneArg [5] = '{8'h81, 8'h8D, 8'hD9, 8'hDA, 8'h20};
    for (int n = 0; n < 50; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: sendByte(8'($urandom), 1'b1);
        4: sendByte(($urandom_range(0, 1) == 0) ? singles[$urandom_range(0, 5)] : 8'($urandom_range(0, 23)), 1'b0);
        5: begin sendByte(oneArg[$urandom_range(0, 4)], 1'b0); sendByte(8'($urandom), 1'b0); end
        6, 7: begin
          sendByte(8'h21 + 8'($urandom_range(0, 1)), 1'b0);
          sendByte(8'($urandom), 1'b0);
          sendByte(8'($urandom), 1'b0);
        end
        8: sendByte(8'h30 + 8'($urandom_range(0, 15)), 1'b0);
        default: begin sendByte(oneArg[$urandom_range(0, 4)], 1'b0); sendByte(8'($urandom), 1'b1); end
      endcase
    end
    settle();
    total++;
    if (obsValid.size() != expValid.size() || obsWrite.size() != expWrite.size()) begin
      bad++; $display("[TB] FAIL rand_counts: got %0d/%0d want %0d/%0d", obsValid.size(), obsWrite.size(),
                      expValid.size(), expWrite.size());
    end
    foreach (expValid[i]) if (i < obsValid.size()) begin
      total++;
      if (obsValid[i] !== expValid[i]) begin
        bad++; $display("[TB] FAIL rand_byte%0d: got %h/%b@%0d want %h/%b@%0d", i, obsValid[i].data,
                        obsValid[i].dc, obsValid[i].stamp, expValid[i].data, expValid[i].dc, expValid[i].stamp);
      end
    end
    foreach (expWrite[i]) if (i < obsWrite.size()) begin
      total++;
      if (obsWrite[i] !== expWrite[i]) begin
        bad++; $display("[TB] FAIL rand_write%0d: got %h<=%h@%0d want %h<=%h@%0d", i, obsWrite[i].addr,
                        obsWrite[i].data, obsWrite[i].stamp, expWrite[i].addr, expWrite[i].data, expWrite[i].stamp);
      end
    end
    total++;
    if (obsErr !== expErr) begin bad++; $display("[TB] FAIL rand_errors: got %0d want %0d", obsErr, expErr); end
    total++;
    if (dutStatus() !== modelStatus()) begin
      bad++; $display("[TB] FAIL rand_status: got %h want %h", dutStatus(), modelStatus());
    end
    clearQueues();
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_page_write();
    test_horz_wrap();
    test_arg_error();
    test_drop();
    test_display_reset();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
